sync_debounce: RTL and testbench

- Parametrised successor to the team's single-bit two-flop synchroniser.
- Brings WIDTH independent asynchronous inputs into the clk domain through a configurable-depth flop chain.
- Filters each synchronised bit with a per-channel stability (debounce) counter.
- Emits a debounced level plus one-cycle rise/fall pulses per channel. Intended for pushbuttons, external status pins and slow cross-domain flags.

---
 rtl/sync_pkg.sv | 25 ++
 rtl/sync_chain.sv | 45 ++++
 rtl/sync_debounce.sv | 127 ++++++++++++
 tb/tb_sync_debounce.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sync_pkg
// Purpose  : Shared constants and helpers for the synchroniser/debounce slice.
//            - SYNC_MIN_STAGES : smallest legal synchroniser depth
//            - SYNC_MIN_DB     : smallest legal debounce length
//            - db_cnt_w()      : width of a counter that counts 0..n-1,
//                                never narrower than one bit
// Revision : 1.0 - initial release
// ============================================================================
package sync_pkg;

  localparam int SYNC_MIN_STAGES = 2;
  localparam int SYNC_MIN_DB     = 1;

  // A debounce length of 1 only ever needs the value 0, which $clog2 reports
  // as zero bits; keep at least one bit so the counter stays a real vector.
  function automatic int db_cnt_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : sync_pkg
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// ============================================================================
// Module   : sync_chain
// Purpose  : Single-bit metastability synchroniser, STAGES flops deep, with
//            an asynchronous active-low reset to a 1-bit reset value.
// Ports    : clk     - destination clock, rising edge
//            reset_n - asynchronous active-low reset
//            d       - asynchronous input bit
//            q       - synchronised bit (last flop of the chain)
// Revision : 1.0 - initial release
// ============================================================================
module sync_chain
  import sync_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  if (STAGES < SYNC_MIN_STAGES) begin : g_chk_stages
    $error("sync_chain: STAGES must be >= %0d", SYNC_MIN_STAGES);
  end

  // The attributes keep the chain flops from being merged, retimed or pushed
  // into SRLs and let the tools place them back to back for maximum MTBF.
  (* ASYNC_REG = "TRUE", keep = "true" *)
  logic [STAGES-1:0] r_stage;

  // Bit 0 samples the raw input; each edge shifts one position toward MSB.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stage <= {STAGES{RESET_VAL}};
    end else begin
      r_stage <= {r_stage[STAGES-2:0], d};
    end
  end

  assign q = r_stage[STAGES-1];

endmodule : sync_chain
`default_nettype wire

// File: rtl/sync_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sync_debounce
// Purpose  : WIDTH independent asynchronous inputs are synchronised through
//            STAGES-deep flop chains, then each synchronised bit is filtered
//            by a stability counter. The level only follows the synchronised
//            value once it has disagreed with the level for DB_CYCLES
//            consecutive cycles; the change is flagged by a one-cycle rise or
//            fall pulse.
// Ports    : clk     - sole clock, all flops rising edge
//            reset_n - asynchronous active-low reset (release is assumed to
//                      be synchronised to clk upstream)
//            d       - WIDTH raw asynchronous inputs
//            q       - WIDTH synchronised raw values (chain outputs)
//            level   - WIDTH debounced levels
//            rise    - WIDTH one-cycle pulses on level 0->1
//            fall    - WIDTH one-cycle pulses on level 1->0
//            Every output is a flop output; nothing is combinational from d.
// Revision : 1.0 - initial release
// ============================================================================
module sync_debounce
  import sync_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               STAGES    = 2,
  parameter int               DB_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // --------------------------------------------------------------------------
  // Parameter legality
  // --------------------------------------------------------------------------
  if (WIDTH < 1) begin : g_chk_width
    $error("sync_debounce: WIDTH must be >= 1");
  end

  if (STAGES < SYNC_MIN_STAGES) begin : g_chk_stages
    $error("sync_debounce: STAGES must be >= %0d", SYNC_MIN_STAGES);
  end

  if (DB_CYCLES < SYNC_MIN_DB) begin : g_chk_db
    $error("sync_debounce: DB_CYCLES must be >= %0d", SYNC_MIN_DB);
  end

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int                 c_cnt_w   = db_cnt_w(DB_CYCLES);
  // Terminal count: the disagreement has been seen DB_CYCLES times once the
  // counter already holds DB_CYCLES-1 and the mismatch is still present.
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DB_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  // --------------------------------------------------------------------------
  // Per-channel synchroniser + debounce
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch

    sync_chain #(
      .STAGES    (STAGES),
      .RESET_VAL (RESET_VAL[i])
    ) u_chain (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (d[i]),
      .q       (w_q[i])
    );

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_level;
    logic               r_rise;
    logic               r_fall;
    logic               w_diff;
    logic               w_done;

    // w_diff: synchronised value disagrees with the debounced level.
    // w_done: that disagreement has now lasted DB_CYCLES consecutive edges.
    assign w_diff = w_q[i] ^ r_level;
    assign w_done = w_diff && (r_cnt == c_cnt_max);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt   <= '0;
        r_level <= RESET_VAL[i];
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
      end else begin
        // Pulses are recomputed every edge, so they last exactly one cycle.
        // Only one of them can be set since w_q[i] selects the direction.
        r_rise <= w_done &  w_q[i];
        r_fall <= w_done & ~w_q[i];

        if (w_done) begin
          r_level <= w_q[i];
          r_cnt   <= '0;
        end else if (w_diff) begin
          // Cannot overflow: reaching c_cnt_max with w_diff takes the branch
          // above, and a cleared mismatch drops to the branch below.
          r_cnt   <= r_cnt + c_cnt_one;
        end else begin
          // A glitch shorter than DB_CYCLES ends here; level is untouched and
          // the next mismatch counts from zero again.
          r_cnt   <= '0;
        end
      end
    end

    assign level[i] = r_level;
    assign rise[i]  = r_rise;
    assign fall[i]  = r_fall;

  end : g_ch

  assign q = w_q;

endmodule : sync_debounce
`default_nettype wire

// File: tb/tb_sync_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_debounce
// Purpose  : Directed self-checking bench for sync_debounce. A default
//            instance (WIDTH=4, STAGES=2, DB_CYCLES=4) covers reset, clean
//            rising/falling steps, glitch rejection, reset mid-count and
//            parallel channels; a second instance (STAGES=3, DB_CYCLES=1)
//            covers the shortest-filter corner. Outputs are sampled on the
//            falling clock edge; inputs also change there.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_debounce;

  logic       clk;
  logic       reset_n;
  logic [3:0] d;
  logic [3:0] q, level, rise, fall;
  logic [3:0] dc;
  logic [3:0] qc, levelc, risec, fallc;

  int n_checks = 0;
  int n_errors = 0;

  sync_debounce #(
    .WIDTH     (4),
    .STAGES    (2),
    .DB_CYCLES (4),
    .RESET_VAL (4'h0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (d),
    .q       (q),
    .level   (level),
    .rise    (rise),
    .fall    (fall)
  );

  sync_debounce #(
    .WIDTH     (4),
    .STAGES    (3),
    .DB_CYCLES (1),
    .RESET_VAL (4'h0)
  ) dut_c (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (dc),
    .q       (qc),
    .level   (levelc),
    .rise    (risec),
    .fall    (fallc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected values after edge k (index k-1) following the input change.
  // Clean step on ch0 with a 2-cycle-wide q excursion on ch1.
  localparam logic [3:0] B_Q [8] = '{4'h0, 4'h3, 4'h3, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
  localparam logic [3:0] B_L [8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1};
  localparam logic [3:0] B_R [8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0};
  // Falling step on ch0.
  localparam logic [3:0] C_Q [8] = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
  localparam logic [3:0] C_L [8] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
  localparam logic [3:0] C_F [8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0};
  // ch2 held high across a reset release.
  localparam logic [3:0] D_Q [7] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4};
  localparam logic [3:0] D_L [7] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4};
  localparam logic [3:0] D_R [7] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0};
  // All channels step together.
  localparam logic [3:0] E_Q [7] = '{4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
  localparam logic [3:0] E_L [7] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF};
  localparam logic [3:0] E_R [7] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0};
  // Corner instance, STAGES=3 DB_CYCLES=1: level follows after edge 4.
  localparam logic [3:0] F_Q [5] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1};
  localparam logic [3:0] F_L [5] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h1};
  localparam logic [3:0] F_R [5] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h0};

  task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string ph, input int k, input logic [3:0] eq,
                            input logic [3:0] el, input logic [3:0] er, input logic [3:0] ef);
    check_val($sformatf("%s_q_k%0d", ph, k),     q,     eq);
    check_val($sformatf("%s_level_k%0d", ph, k), level, el);
    check_val($sformatf("%s_rise_k%0d", ph, k),  rise,  er);
    check_val($sformatf("%s_fall_k%0d", ph, k),  fall,  ef);
  endtask

  // Advance to the falling edge after the next rising edge.
  task automatic next_edge();
    @(posedge clk);
    #5;
  endtask

  // Reset both instances with all inputs low and let the chains settle.
  task automatic do_reset();
    reset_n = 1'b0;
    d       = 4'h0;
    dc      = 4'h0;
    next_edge();
    next_edge();
    reset_n = 1'b1;
    next_edge();
    next_edge();
  endtask

  initial begin
    reset_n = 1'b1;
    d       = 4'hF;
    dc      = 4'h0;

    // ---- Reset with d=F: async assertion, release at t=12 ----
    #1 reset_n = 1'b0;
    #1;
    check_outs("rst_async", 0, 4'h0, 4'h0, 4'h0, 4'h0);
    check_val("rst_async_qc", qc, 4'h0);
    check_val("rst_async_levelc", levelc, 4'h0);
    next_edge();                                   // t=10, edge at 5 in reset
    check_outs("rst_hold", 0, 4'h0, 4'h0, 4'h0, 4'h0);
    #2 reset_n = 1'b1;                             // t=12
    next_edge();                                   // t=20, after E1
    check_val("rst_rel_q_e1", q, 4'h0);
    next_edge();                                   // t=30, after E2
    check_val("rst_rel_q_e2", q, 4'hF);
    check_val("rst_rel_level_e2", level, 4'h0);
    next_edge(); next_edge(); next_edge();         // t=60, after E5
    check_val("rst_rel_level_e5", level, 4'h0);
    next_edge();                                   // t=70, after E6
    check_val("rst_rel_level_e6", level, 4'hF);
    check_val("rst_rel_rise_e6", rise, 4'hF);
    next_edge();
    check_val("rst_rel_rise_e7", rise, 4'h0);

    // ---- Clean step on ch0, glitch on ch1 ----
    do_reset();
    d = 4'b0011;
    for (int k = 1; k <= 8; k++) begin
      next_edge();
      check_outs("step", k, B_Q[k-1], B_L[k-1], B_R[k-1], 4'h0);
      if (k == 2) d = 4'b0001;                     // ch1 was high across two edges
    end

    // ---- Falling step on ch0 ----
    d = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      next_edge();
      check_outs("fallstep", k, C_Q[k-1], C_L[k-1], 4'h0, C_F[k-1]);
    end

    // ---- Reset in the middle of a count on ch2 ----
    d = 4'b0100;
    next_edge(); next_edge(); next_edge(); next_edge();   // ch2 counter at 2
    check_val("midrst_q_pre", q, 4'h4);
    check_val("midrst_level_pre", level, 4'h0);
    #1 reset_n = 1'b0;
    #1;                                            // no clock edge yet
    check_outs("midrst_async", 0, 4'h0, 4'h0, 4'h0, 4'h0);
    next_edge();
    check_outs("midrst_hold", 0, 4'h0, 4'h0, 4'h0, 4'h0);
    reset_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      next_edge();
      check_outs("midrst_rel", k, D_Q[k-1], D_L[k-1], D_R[k-1], 4'h0);
    end

    // ---- All channels step together ----
    do_reset();
    d = 4'hF;
    for (int k = 1; k <= 7; k++) begin
      next_edge();
      check_outs("par", k, E_Q[k-1], E_L[k-1], E_R[k-1], 4'h0);
    end

    // ---- Corner configuration: STAGES=3, DB_CYCLES=1 ----
    do_reset();
    check_val("corner_level_rst", levelc, 4'h0);
    dc = 4'b0001;
    for (int k = 1; k <= 5; k++) begin
      next_edge();
      check_val($sformatf("corner_q_k%0d", k),     qc,     F_Q[k-1]);
      check_val($sformatf("corner_level_k%0d", k), levelc, F_L[k-1]);
      check_val($sformatf("corner_rise_k%0d", k),  risec,  F_R[k-1]);
      check_val($sformatf("corner_fall_k%0d", k),  fallc,  4'h0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule : tb_sync_debounce
`default_nettype wire
